// File: rtl/vic_video_pkg.sv
// Shared types and defaults for the VIC-II video sync decoder.
package vic_video_pkg;

   localparam int unsigned CNT_W_DEF = 10;

   typedef logic [11:0] rgb12_t;

   typedef enum logic [1:0] {
      SEARCH,
      MEASURE,
      LOCKED
   } sync_state_t;

   function automatic rgb12_t pack_rgb(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
      return {r, g, b};
   endfunction

endpackage

// File: rtl/vic_sync_edge_detect.sv
// Normalises a sync input to active-high and flags its leading edge on enabled samples.
module vic_sync_edge_detect #(
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic pix_en_i,
   input  logic sync_i,
   output logic edge_o
);

   logic active;
   logic prev_q;

   assign active = ACTIVE_LOW ? ~sync_i : sync_i;

   always_ff @(posedge clk) begin
      if (reset) begin
         prev_q <= 1'b0;
      end else if (pix_en_i) begin
         prev_q <= active;
      end
   end

   assign edge_o = pix_en_i & active & ~prev_q;

endmodule

// File: rtl/vic_video_sync_decoder.sv
// Recovers raster position and timing from VIC-II video output, declares lock,
// and re-emits active pixels with a per-frame checksum.
module vic_video_sync_decoder
   import vic_video_pkg::*;
#(
   parameter int unsigned CNT_W           = CNT_W_DEF,
   parameter bit          SYNC_ACTIVE_LOW = 1'b1,
   parameter int unsigned LOCK_FRAMES     = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_pix_en,
   input  logic             i_hsync,
   input  logic             i_vsync,
   input  logic             i_display_on,
   input  logic [3:0]       i_red,
   input  logic [3:0]       i_green,
   input  logic [3:0]       i_blue,
   output logic [CNT_W-1:0] o_hpos,
   output logic [CNT_W-1:0] o_vpos,
   output logic [CNT_W-1:0] o_line_len,
   output logic [CNT_W-1:0] o_frame_lines,
   output logic             o_locked,
   output logic             o_frame_start,
   output logic             o_pix_valid,
   output logic [11:0]      o_rgb,
   output logic [15:0]      o_checksum,
   output logic             o_checksum_valid
);

   localparam int unsigned GW = $clog2(LOCK_FRAMES + 1);

   sync_state_t      state_q, state_d;
   logic [GW-1:0]    good_cnt_q, good_cnt_d, good_inc;
   logic             have_ref_q, have_ref_d;

   logic [CNT_W-1:0] hcnt_q, vcnt_q, line_len_q, frame_lines_q, line_ref_q;
   logic             ref_valid_q, mismatch_q, full_q;
   logic             frame_start_q, csv_q, pix_valid_q;
   rgb12_t           rgb_q;
   logic [15:0]      acc_q, checksum_q;

   logic             h_edge, v_edge, sat, line_bad, frame_good, locked_d;
   logic [CNT_W-1:0] line_len_new, lines_new;
   rgb12_t           rgb_now;
   logic [15:0]      contrib;

   vic_sync_edge_detect #(.ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_hsync_edge (
      .clk      (clk),
      .reset    (reset),
      .pix_en_i (i_pix_en),
      .sync_i   (i_hsync),
      .edge_o   (h_edge)
   );

   vic_sync_edge_detect #(.ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_vsync_edge (
      .clk      (clk),
      .reset    (reset),
      .pix_en_i (i_pix_en),
      .sync_i   (i_vsync),
      .edge_o   (v_edge)
   );

   assign sat          = i_pix_en & (hcnt_q == '1) & ~h_edge;
   assign line_len_new = hcnt_q + 1'b1;
   assign lines_new    = vcnt_q + CNT_W'(h_edge);
   // A coincident H edge closes the last line of the frame, so it is judged with it.
   assign line_bad     = h_edge & ref_valid_q & (line_len_new != line_ref_q);
   assign frame_good   = ~(mismatch_q | line_bad) & (~have_ref_q | (lines_new == frame_lines_q));
   assign good_inc     = good_cnt_q + 1'b1;
   assign locked_d     = (state_d == LOCKED);
   assign rgb_now      = pack_rgb(i_red, i_green, i_blue);
   assign contrib      = (i_display_on && locked_d) ? {4'b0000, rgb_now} : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= SEARCH;
         good_cnt_q <= '0;
         have_ref_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         good_cnt_q <= good_cnt_d;
         have_ref_q <= have_ref_d;
      end
   end

   // The first closed frame is the reference and also opens the run of good frames.
   always_comb begin
      state_d    = state_q;
      good_cnt_d = good_cnt_q;
      have_ref_d = have_ref_q;
      if (sat) begin
         state_d = SEARCH;
      end else if (i_pix_en) begin
         case (state_q)
            SEARCH: begin
               if (v_edge) begin
                  state_d    = MEASURE;
                  good_cnt_d = '0;
                  have_ref_d = 1'b0;
               end
            end
            MEASURE: begin
               if (v_edge) begin
                  have_ref_d = 1'b1;
                  if (frame_good) begin
                     good_cnt_d = good_inc;
                     if (good_inc == GW'(LOCK_FRAMES)) state_d = LOCKED;
                  end else begin
                     good_cnt_d = '0;
                  end
               end
            end
            LOCKED: begin
               if (line_bad || (v_edge && !frame_good)) state_d = SEARCH;
            end
            default: state_d = SEARCH;
         endcase
      end
   end

   always_comb begin
      o_locked = (state_q == LOCKED);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hcnt_q        <= '0;
         vcnt_q        <= '0;
         line_len_q    <= '0;
         frame_lines_q <= '0;
         line_ref_q    <= '0;
         ref_valid_q   <= 1'b0;
         mismatch_q    <= 1'b0;
         full_q        <= 1'b0;
         frame_start_q <= 1'b0;
         csv_q         <= 1'b0;
         pix_valid_q   <= 1'b0;
         rgb_q         <= '0;
         acc_q         <= '0;
         checksum_q    <= '0;
      end else begin
         frame_start_q <= 1'b0;
         csv_q         <= 1'b0;
         if (i_pix_en) begin
            if (h_edge) begin
               hcnt_q     <= '0;
               line_len_q <= line_len_new;
            end else if (hcnt_q != '1) begin
               hcnt_q <= hcnt_q + 1'b1;
            end

            if (v_edge) begin
               vcnt_q        <= '0;
               frame_lines_q <= lines_new;
               ref_valid_q   <= 1'b0;
               mismatch_q    <= 1'b0;
            end else if (h_edge) begin
               vcnt_q <= vcnt_q + 1'b1;
               if (!ref_valid_q) begin
                  line_ref_q  <= line_len_new;
                  ref_valid_q <= 1'b1;
               end else if (line_bad) begin
                  mismatch_q <= 1'b1;
               end
            end

            frame_start_q <= v_edge;
            pix_valid_q   <= i_display_on & locked_d;
            rgb_q         <= rgb_now;

            if (v_edge) begin
               checksum_q <= acc_q;
               csv_q      <= full_q & locked_d;
               acc_q      <= contrib;
            end else begin
               acc_q <= acc_q + contrib;
            end

            // full_q: lock has held since the opening V edge of the current frame.
            if (!locked_d)   full_q <= 1'b0;
            else if (v_edge) full_q <= 1'b1;
         end
      end
   end

   assign o_hpos           = hcnt_q;
   assign o_vpos           = vcnt_q;
   assign o_line_len       = line_len_q;
   assign o_frame_lines    = frame_lines_q;
   assign o_frame_start    = frame_start_q;
   assign o_pix_valid      = pix_valid_q;
   assign o_rgb            = rgb_q;
   assign o_checksum       = checksum_q;
   assign o_checksum_valid = csv_q;

endmodule

// File: tb/tb_vic_video_sync_decoder.sv
// Directed bench: 100-pixel x 12-line raster at half-rate pixel enable, driving an
// active-low-sync and an active-high-sync instance with identical expectations.
module tb_vic_video_sync_decoder;

   logic        clk = 1'b0;
   logic        reset, pix_en, hs, vs, de;
   logic [11:0] rgb_in;

   always #5 clk = ~clk;

   logic [9:0]  a_hpos, a_vpos, a_len, a_lines, b_hpos, b_vpos, b_len, b_lines;
   logic        a_lock, a_fs, a_pv, a_csv, b_lock, b_fs, b_pv, b_csv;
   logic [11:0] a_rgb, b_rgb;
   logic [15:0] a_cs, b_cs;

   vic_video_sync_decoder #(.CNT_W(10), .SYNC_ACTIVE_LOW(1'b1), .LOCK_FRAMES(2)) dut_a (
      .clk(clk), .reset(reset), .i_pix_en(pix_en), .i_hsync(~hs), .i_vsync(~vs),
      .i_display_on(de), .i_red(rgb_in[11:8]), .i_green(rgb_in[7:4]), .i_blue(rgb_in[3:0]),
      .o_hpos(a_hpos), .o_vpos(a_vpos), .o_line_len(a_len), .o_frame_lines(a_lines),
      .o_locked(a_lock), .o_frame_start(a_fs), .o_pix_valid(a_pv), .o_rgb(a_rgb),
      .o_checksum(a_cs), .o_checksum_valid(a_csv)
   );

   vic_video_sync_decoder #(.CNT_W(10), .SYNC_ACTIVE_LOW(1'b0), .LOCK_FRAMES(2)) dut_b (
      .clk(clk), .reset(reset), .i_pix_en(pix_en), .i_hsync(hs), .i_vsync(vs),
      .i_display_on(de), .i_red(rgb_in[11:8]), .i_green(rgb_in[7:4]), .i_blue(rgb_in[3:0]),
      .o_hpos(b_hpos), .o_vpos(b_vpos), .o_line_len(b_len), .o_frame_lines(b_lines),
      .o_locked(b_lock), .o_frame_start(b_fs), .o_pix_valid(b_pv), .o_rgb(b_rgb),
      .o_checksum(b_cs), .o_checksum_valid(b_csv)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk2(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
      chk({"A ", name}, a, exp);
      chk({"B ", name}, b, exp);
   endtask

   logic cap_fs_a, cap_fs_b, cap_csv_a, cap_csv_b;

   // One enabled sample followed by one disabled clock (pix_en every 2nd clk).
   task automatic do_sample(input logic h, input logic v, input logic d, input logic [11:0] c);
      hs = h; vs = v; de = d; rgb_in = c; pix_en = 1'b1;
      @(posedge clk); #1;
      cap_fs_a = a_fs; cap_fs_b = b_fs; cap_csv_a = a_csv; cap_csv_b = b_csv;
      pix_en = 1'b0;
      @(posedge clk); #1;
   endtask

   typedef struct {
      int          lines;
      int          drive_lines;
      int          short_line;
      logic [11:0] colour;
      int          e_lines;
      int          e_len;
      bit          e_locked;
      bit          e_csv;
      logic [15:0] e_cs;
      bit          e_mid_valid;
   } row_t;

   row_t rows[12];

   // Each row drives one frame; expectations are checked at its opening V edge.
   task automatic run_row(input int r);
      row_t rw;
      rw = rows[r];
      for (int l = 0; l < rw.drive_lines; l++) begin
         int len;
         len = (l == rw.short_line) ? 99 : 100;
         for (int p = 0; p < len; p++) begin
            logic d;
            d = (l >= 3) && (l <= 10) && (p >= 20) && (p <= 35) && (l < rw.lines);
            do_sample(p < 10, l < 2, d, d ? rw.colour : 12'hFFF);
            if (l == 0 && p == 0) begin
               chk2($sformatf("r%0d frame_start", r), 32'(cap_fs_a), 32'(cap_fs_b), 1);
               chk2($sformatf("r%0d csum_valid", r), 32'(cap_csv_a), 32'(cap_csv_b), 32'(rw.e_csv));
               chk2($sformatf("r%0d frame_lines", r), 32'(a_lines), 32'(b_lines), rw.e_lines);
               chk2($sformatf("r%0d line_len", r), 32'(a_len), 32'(b_len), rw.e_len);
               chk2($sformatf("r%0d locked", r), 32'(a_lock), 32'(b_lock), 32'(rw.e_locked));
               chk2($sformatf("r%0d checksum", r), 32'(a_cs), 32'(b_cs), 32'(rw.e_cs));
               chk2($sformatf("r%0d vpos0", r), 32'(a_vpos), 32'(b_vpos), 0);
               chk2($sformatf("r%0d hpos0", r), 32'(a_hpos), 32'(b_hpos), 0);
               chk2($sformatf("r%0d fs_drop", r), 32'(a_fs), 32'(b_fs), 0);
               chk2($sformatf("r%0d csv_drop", r), 32'(a_csv), 32'(b_csv), 0);
            end
            if (l == 3 && p == 20) begin
               chk2($sformatf("r%0d mid hpos", r), 32'(a_hpos), 32'(b_hpos), 20);
               chk2($sformatf("r%0d mid vpos", r), 32'(a_vpos), 32'(b_vpos), 3);
               chk2($sformatf("r%0d mid pix_valid", r), 32'(a_pv), 32'(b_pv), 32'(rw.e_mid_valid));
               if (rw.e_mid_valid)
                  chk2($sformatf("r%0d mid rgb", r), 32'(a_rgb), 32'(b_rgb), 32'(rw.colour));
            end
            if (rw.short_line >= 0 && l == rw.short_line && p == 0)
               chk2($sformatf("r%0d pre-short locked", r), 32'(a_lock), 32'(b_lock), 1);
            if (rw.short_line >= 0 && l == rw.short_line + 1 && p == 0) begin
               chk2($sformatf("r%0d short locked", r), 32'(a_lock), 32'(b_lock), 0);
               chk2($sformatf("r%0d short line_len", r), 32'(a_len), 32'(b_len), 99);
            end
         end
      end
   endtask

   task automatic reset_and_check(input string tag);
      reset = 1'b1; pix_en = 1'b0; hs = 1'b0; vs = 1'b0; de = 1'b0; rgb_in = '0;
      @(posedge clk); #1;
      chk2({tag, " locked after 1 clk"}, 32'(a_lock), 32'(b_lock), 0);
      repeat (2) @(posedge clk);
      #1;
      chk2({tag, " hpos"}, 32'(a_hpos), 32'(b_hpos), 0);
      chk2({tag, " vpos"}, 32'(a_vpos), 32'(b_vpos), 0);
      chk2({tag, " line_len"}, 32'(a_len), 32'(b_len), 0);
      chk2({tag, " frame_lines"}, 32'(a_lines), 32'(b_lines), 0);
      chk2({tag, " frame_start"}, 32'(a_fs), 32'(b_fs), 0);
      chk2({tag, " pix_valid"}, 32'(a_pv), 32'(b_pv), 0);
      chk2({tag, " rgb"}, 32'(a_rgb), 32'(b_rgb), 0);
      chk2({tag, " checksum"}, 32'(a_cs), 32'(b_cs), 0);
      chk2({tag, " csum_valid"}, 32'(a_csv), 32'(b_csv), 0);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; pix_en = 1'b0; hs = 1'b0; vs = 1'b0; de = 1'b0; rgb_in = '0;

      //            lines drv short colour   e_lines e_len lock csv cs        mid
      rows[0]  = '{12, 12, -1, 12'h000,  1,   1,  1'b0, 1'b0, 16'h0000, 1'b0};
      rows[1]  = '{12, 12, -1, 12'h000, 12, 100,  1'b0, 1'b0, 16'h0000, 1'b0};
      rows[2]  = '{12, 12, -1, 12'h44C, 12, 100,  1'b1, 1'b0, 16'h0000, 1'b1};
      rows[3]  = '{12, 12, -1, 12'h123, 12, 100,  1'b1, 1'b1, 16'h2600, 1'b1};
      rows[4]  = '{12, 12,  5, 12'h44C, 12, 100,  1'b1, 1'b1, 16'h9180, 1'b1};
      rows[5]  = '{12, 12, -1, 12'h000, 12, 100,  1'b0, 1'b0, 16'hCE40, 1'b0};
      rows[6]  = '{12, 12, -1, 12'h000, 12, 100,  1'b0, 1'b0, 16'h0000, 1'b0};
      rows[7]  = '{11, 11, -1, 12'h001, 12, 100,  1'b1, 1'b0, 16'h0000, 1'b1};
      rows[8]  = '{12, 12, -1, 12'h000, 11, 100,  1'b0, 1'b0, 16'h0080, 1'b0};
      rows[9]  = '{12, 12, -1, 12'h000, 12, 100,  1'b0, 1'b0, 16'h0000, 1'b0};
      rows[10] = '{12, 12, -1, 12'h000, 12, 100,  1'b0, 1'b0, 16'h0000, 1'b0};
      rows[11] = '{12,  5, -1, 12'h000, 12, 100,  1'b1, 1'b0, 16'h0000, 1'b1};

      reset_and_check("por");

      for (int r = 0; r < 12; r++) run_row(r);

      chk2("pre-reset locked", 32'(a_lock), 32'(b_lock), 1);
      reset_and_check("midframe");

      for (int r = 0; r < 3; r++) run_row(r);

      // Closing V edge of the locked colour frame, then a line with no hsync.
      do_sample(1'b1, 1'b1, 1'b0, 12'hFFF);
      chk2("sat-open locked", 32'(a_lock), 32'(b_lock), 1);
      chk2("sat-open csum_valid", 32'(cap_csv_a), 32'(cap_csv_b), 1);
      chk2("sat-open checksum", 32'(a_cs), 32'(b_cs), 32'h2600);
      for (int k = 1; k <= 1024; k++) begin
         do_sample(k < 10, k < 200, 1'b0, 12'hFFF);
         if (k == 1023) begin
            chk2("sat hpos at 1023", 32'(a_hpos), 32'(b_hpos), 1023);
            chk2("sat locked at 1023", 32'(a_lock), 32'(b_lock), 1);
         end
         if (k == 1024) begin
            chk2("sat hpos held", 32'(a_hpos), 32'(b_hpos), 1023);
            chk2("sat locked dropped", 32'(a_lock), 32'(b_lock), 0);
            chk2("sat vpos", 32'(a_vpos), 32'(b_vpos), 0);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
